// File: rtl/vga_pixel_source.sv
// VGA pixel-stream source: timing counters, frame-buffer fetch strobe and a
// two-stage pipeline presenting aligned RGB/grey, position, index and syncs.
module vga_pixel_source #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_ce,
  output logic        rd_en,
  output logic [19:0] rd_addr,
  input  logic [7:0]  r_in,
  input  logic [7:0]  g_in,
  input  logic [7:0]  b_in,
  output logic [7:0]  grey_out,
  output logic [7:0]  r_out,
  output logic [7:0]  g_out,
  output logic [7:0]  b_out,
  output logic        en,
  output logic [10:0] vga_x,
  output logic [10:0] vga_y,
  output logic [19:0] vga_addr,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic        active;

  logic [10:0] s1_h_q, s1_v_q;
  logic [19:0] s1_addr_q, s1_addr_d;
  logic        s1_act_q, s1_hs_q, s1_vs_q, s1_fs_q;
  logic        s1_hs_d, s1_vs_d, s1_fs_d;

  logic [7:0]  grey_q, grey_d, r_q, r_d, g_q, g_d, b_q, b_d;
  logic [15:0] sum;

  assign active  = (h_cnt_q < 11'(H_ACTIVE)) && (v_cnt_q < 11'(V_ACTIVE));
  assign rd_en   = pix_ce & active;
  assign rd_addr = 20'(v_cnt_q) * 20'(H_ACTIVE) + 20'(h_cnt_q);

  always_comb begin
    h_cnt_d = h_cnt_q + 11'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 11'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else if (pix_ce) begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // The held index doubles as the blanking-time value of vga_addr.
  always_comb begin
    s1_addr_d = active ? rd_addr : s1_addr_q;
    s1_hs_d   = ((h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ? SYNC_POL : ~SYNC_POL;
    s1_vs_d   = ((v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ? SYNC_POL : ~SYNC_POL;
    s1_fs_d   = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_h_q    <= '0;
      s1_v_q    <= '0;
      s1_addr_q <= '0;
      s1_act_q  <= 1'b0;
      s1_hs_q   <= ~SYNC_POL;
      s1_vs_q   <= ~SYNC_POL;
      s1_fs_q   <= 1'b0;
    end else if (pix_ce) begin
      s1_h_q    <= h_cnt_q;
      s1_v_q    <= v_cnt_q;
      s1_addr_q <= s1_addr_d;
      s1_act_q  <= active;
      s1_hs_q   <= s1_hs_d;
      s1_vs_q   <= s1_vs_d;
      s1_fs_q   <= s1_fs_d;
    end
  end

  // Read data arrives one advance after rd_en, so colour enters at stage 2.
  always_comb begin
    sum    = 16'd77 * 16'(r_in) + 16'd150 * 16'(g_in) + 16'd29 * 16'(b_in);
    grey_d = s1_act_q ? sum[15:8] : '0;
    r_d    = s1_act_q ? r_in : '0;
    g_d    = s1_act_q ? g_in : '0;
    b_d    = s1_act_q ? b_in : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grey_q      <= '0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      en          <= 1'b0;
      vga_x       <= '0;
      vga_y       <= '0;
      vga_addr    <= '0;
      vga_hs      <= ~SYNC_POL;
      vga_vs      <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else if (pix_ce) begin
      grey_q      <= grey_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
      en          <= s1_act_q;
      vga_x       <= s1_h_q;
      vga_y       <= s1_v_q;
      vga_addr    <= s1_addr_q;
      vga_hs      <= s1_hs_q;
      vga_vs      <= s1_vs_q;
      frame_start <= s1_fs_q;
    end
  end

  assign grey_out = grey_q;
  assign r_out    = r_q;
  assign g_out    = g_q;
  assign b_out    = b_q;

endmodule

// File: tb/tb_vga_pixel_source.sv
// Bench for vga_pixel_source on a reduced raster: scoreboard of expected
// outputs per advance, plus table of colour vectors and frame-level sequences.
module tb_vga_pixel_source;

  localparam int HA = 16, HFP = 2, HS = 4, HBP = 3;
  localparam int VA = 6,  VFP = 2, VS = 2, VBP = 3;
  localparam bit SP = 1'b0;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int NPIX = HA * VA;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_ce = 1'b1;
  logic        rd_en;
  logic [19:0] rd_addr;
  logic [7:0]  r_in, g_in, b_in;
  logic [7:0]  grey_out, r_out, g_out, b_out;
  logic        en;
  logic [10:0] vga_x, vga_y;
  logic [19:0] vga_addr;
  logic        vga_hs, vga_vs, frame_start;

  vga_pixel_source #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(SP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .grey_out(grey_out), .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .en(en), .vga_x(vga_x), .vga_y(vga_y), .vga_addr(vga_addr),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Frame buffer: synchronous read, data held until the next strobe.
  logic [23:0] mem [0:NPIX-1];
  logic [23:0] rdata = '0;
  always @(posedge clk) if (rd_en) rdata <= mem[rd_addr];
  assign r_in = rdata[23:16];
  assign g_in = rdata[15:8];
  assign b_in = rdata[7:0];

  typedef struct {
    int addr; int r; int g; int b; int grey;
  } vec_t;

  typedef struct {
    int x; int y; logic en; int grey; int r; int g; int b;
    int addr; logic hs; logic vs; logic fs;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   ce_div = 1;
  exp_t q[$];
  exp_t last, rst_rec;
  int   mh = 0, mv = 0, held_addr = 0;
  int   obs_grey [0:NPIX-1];
  vec_t vecs [7];

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  task automatic cmp_out(input string nm, input exp_t e);
    checks++;
    if (vga_x !== 11'(e.x) || vga_y !== 11'(e.y) || en !== e.en || grey_out !== 8'(e.grey) ||
        r_out !== 8'(e.r) || g_out !== 8'(e.g) || b_out !== 8'(e.b) || vga_addr !== 20'(e.addr) ||
        vga_hs !== e.hs || vga_vs !== e.vs || frame_start !== e.fs) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s @%0t: got x=%0d y=%0d en=%b grey=%0d rgb=%0d/%0d/%0d addr=%0d hs=%b vs=%b fs=%b; expected x=%0d y=%0d en=%b grey=%0d rgb=%0d/%0d/%0d addr=%0d hs=%b vs=%b fs=%b",
                 nm, $time, vga_x, vga_y, en, grey_out, r_out, g_out, b_out, vga_addr, vga_hs, vga_vs, frame_start,
                 e.x, e.y, e.en, e.grey, e.r, e.g, e.b, e.addr, e.hs, e.vs, e.fs);
    end
  endtask

  function automatic exp_t model(input int h, input int v);
    exp_t e;
    int a;
    e.x = h; e.y = v;
    e.en = (h < HA) && (v < VA);
    e.r = 0; e.g = 0; e.b = 0; e.grey = 0;
    if (e.en) begin
      held_addr = v * HA + h;
      e.r = int'(mem[held_addr][23:16]);
      e.g = int'(mem[held_addr][15:8]);
      e.b = int'(mem[held_addr][7:0]);
      e.grey = (77 * e.r + 150 * e.g + 29 * e.b) / 256;
    end
    a = held_addr;
    e.addr = a;
    e.hs = (h >= HA + HFP && h < HA + HFP + HS) ? SP : ~SP;
    e.vs = (v >= VA + VFP && v < VA + VFP + VS) ? SP : ~SP;
    e.fs = (h == 0) && (v == 0);
    return e;
  endfunction

  // Scoreboard: push the model of the counter state at each advance, pop two advances later.
  initial begin
    logic ce;
    forever begin
      @(posedge clk);
      ce = pix_ce;
      if (!rst_n) begin
        q.delete();
        mh = 0; mv = 0; held_addr = 0;
        last = rst_rec;
        #2 cmp_out("reset_state", last);
      end else begin
        if (ce) begin
          q.push_back(model(mh, mv));
          if (mh == HT - 1) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
          end else mh++;
          if (q.size() >= 2) last = q.pop_front();
        end
        #2 cmp_out(ce ? "pipe_out" : "hold_out", last);
      end
    end
  end

  // Comb read strobe/address against the model counters.
  initial begin
    int eh, ev;
    logic act;
    forever begin
      @(negedge clk);
      eh = rst_n ? mh : 0;
      ev = rst_n ? mv : 0;
      act = (eh < HA) && (ev < VA);
      chk("rd_en", int'(rd_en), int'(pix_ce & act));
      if (act) chk("rd_addr", int'(rd_addr), ev * HA + eh);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ce_div == 1) pix_ce = 1'b1;
      else pix_ce = ~pix_ce;
    end
  end

  task automatic adv();
    int n = 0;
    do begin @(posedge clk); n++; end while (!pix_ce && n < 8);
    if (!pix_ce) begin
      checks++; errors++;
      $display("FAIL adv_timeout: got no pix_ce in %0d clocks, expected one", n);
    end
    #2;
  endtask

  task automatic wait_fs();
    int n = 0;
    while (frame_start !== 1'b1 && n < 2 * HT * VT) begin adv(); n++; end
    chk("wait_frame_start", int'(frame_start), 1);
  endtask

  task automatic frame_test(input string tag);
    int nen = 0, nhs = 0, nvs = 0, maxa = 0, bad_hs = 0;
    logic prev_hs;
    for (int i = 0; i < NPIX; i++) obs_grey[i] = -1;
    wait_fs();
    prev_hs = vga_hs;
    for (int i = 0; i < HT * VT; i++) begin
      adv();
      if (en) begin
        nen++;
        if (vga_addr < NPIX) obs_grey[vga_addr] = int'(grey_out);
        if (int'(vga_addr) > maxa) maxa = int'(vga_addr);
      end
      if (vga_hs == SP) nhs++;
      if (vga_vs == SP) nvs++;
      if (vga_hs == SP && prev_hs != SP && int'(vga_x) != HA + HFP) bad_hs++;
      prev_hs = vga_hs;
    end
    chk({tag, "_period_fs"}, int'(frame_start), 1);
    chk({tag, "_addr_wrap"}, int'(vga_addr), 0);
    chk({tag, "_en_count"}, nen, NPIX);
    chk({tag, "_hs_count"}, nhs, HS * VT);
    chk({tag, "_vs_count"}, nvs, VS * HT);
    chk({tag, "_hs_start"}, bad_hs, 0);
    chk({tag, "_addr_max"}, maxa, NPIX - 1);
    for (int i = 0; i < 7; i++)
      chk({tag, "_vec_grey"}, obs_grey[vecs[i].addr], vecs[i].grey);
  endtask

  initial begin
    rst_rec = '{x: 0, y: 0, en: 1'b0, grey: 0, r: 0, g: 0, b: 0, addr: 0, hs: ~SP, vs: ~SP, fs: 1'b0};
    last = rst_rec;
    vecs[0] = '{addr: 0,  r: 255, g: 0,   b: 0,   grey: 76};
    vecs[1] = '{addr: 1,  r: 0,   g: 255, b: 0,   grey: 149};
    vecs[2] = '{addr: 2,  r: 0,   g: 0,   b: 255, grey: 28};
    vecs[3] = '{addr: 3,  r: 255, g: 255, b: 255, grey: 255};
    vecs[4] = '{addr: 4,  r: 0,   g: 0,   b: 0,   grey: 0};
    vecs[5] = '{addr: 17, r: 128, g: 128, b: 128, grey: 128};
    vecs[6] = '{addr: 95, r: 1,   g: 1,   b: 1,   grey: 1};
    for (int i = 0; i < NPIX; i++) mem[i] = 24'($urandom);
    for (int i = 0; i < 7; i++)
      mem[vecs[i].addr] = {8'(vecs[i].r), 8'(vecs[i].g), 8'(vecs[i].b)};

    // Reset held with pix_ce active, then release.
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("release_rd_en", int'(rd_en), 1);
    chk("release_rd_addr", int'(rd_addr), 0);

    frame_test("ce1");
    ce_div = 2;
    frame_test("ce2");
    ce_div = 1;

    // Mid-frame reset.
    begin
      int n = 0;
      while (!(vga_x == 11'd10 && vga_y == 11'd3) && n < 2 * HT * VT) begin adv(); n++; end
      chk("reach_mid_frame", int'(vga_x) * 100 + int'(vga_y), 1003);
    end
    #1 rst_n = 1'b0;
    #1 cmp_out("async_reset", rst_rec);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    adv();
    chk("post_rst_en", int'(en), 0);
    chk("post_rst_fs", int'(frame_start), 0);
    adv();
    chk("post_rst_fs2", int'(frame_start), 1);
    chk("post_rst_en2", int'(en), 1);
    chk("post_rst_xy", int'(vga_x) + int'(vga_y), 0);
    chk("post_rst_addr", int'(vga_addr), 0);
    chk("post_rst_grey", int'(grey_out), 76);
    repeat (HT + 5) adv();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 500000");
    $fatal(1, "watchdog");
  end

endmodule
